// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the CPU core (port A) and a DMA / program
// loader engine (port B). From idle the CPU has fixed priority; once a port
// owns the memory it keeps it for a bounded burst while the other port is
// waiting, then hands over with no idle cycle in between. Each granted cycle
// performs exactly one access; the memory is combinational for reads and
// commits writes on the clock edge that ends the cycle.
//
// Ports
//   clk          system clock, rising-edge
//   reset        asynchronous active-low reset (0 = in reset)
//   a_req        CPU request, held until a_ack is sampled high
//   a_addr       CPU address
//   a_write      CPU write (1) / read (0)
//   a_wdata      CPU write data
//   a_rdata      read data to CPU (memory data while A owns the port, else 0)
//   a_ack        CPU access performed this cycle
//   b_*          same set for the DMA / loader
//   address      memory address
//   write        memory write enable (gated by the owner's request)
//   to_memory    memory write data
//   from_memory  memory read data, combinational from address
//   owner        current owner: 00 none, 01 A, 10 B
//
// Parameters
//   MAX_BURST    consecutive granted cycles for one owner while the other
//                port is requesting (1..15)
//   ADDR_W       address width
//   DATA_W       data width
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,

  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,

  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] to_memory,
  input  logic [DATA_W-1:0] from_memory,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_t;

  localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

  owner_t     owner_q, owner_d;
  logic [3:0] burst_q, burst_d;

  // One bit wider than the counter so burst_cnt+1 cannot wrap before the
  // comparison against the burst limit.
  logic [4:0] burst_next;
  logic       limit_hit;
  logic [3:0] burst_inc;

  assign burst_next = {1'b0, burst_q} + 5'd1;
  assign limit_hit  = (burst_next >= BURST_LIMIT);
  // The counter only matters while the other port waits, but it keeps
  // counting during uncontended bursts, so it must not wrap back to 0.
  assign burst_inc  = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;

  // ---------------------------------------------------------------------------
  // Next owner / burst counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    owner_d = owner_q;
    burst_d = burst_q;

    unique case (owner_q)
      OWN_NONE: begin
        burst_d = 4'd0;
        if (a_req)      owner_d = OWN_A;
        else if (b_req) owner_d = OWN_B;
      end

      OWN_A: begin
        if (a_req) begin
          if (b_req && limit_hit) begin
            owner_d = OWN_B;
            burst_d = 4'd0;
          end else begin
            burst_d = burst_inc;
          end
        end else begin
          owner_d = b_req ? OWN_B : OWN_NONE;
          burst_d = 4'd0;
        end
      end

      OWN_B: begin
        if (b_req) begin
          if (a_req && limit_hit) begin
            owner_d = OWN_A;
            burst_d = 4'd0;
          end else begin
            burst_d = burst_inc;
          end
        end else begin
          owner_d = a_req ? OWN_A : OWN_NONE;
          burst_d = 4'd0;
        end
      end

      default: begin
        owner_d = OWN_NONE;
        burst_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      burst_q <= 4'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its _d value from before this edge, regardless of order.
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Port decode. Everything is combinational from owner_q, so an asynchronous
  // reset drops write and both acks immediately, without waiting for a clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    address   = '0;
    write     = 1'b0;
    to_memory = '0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    a_rdata   = '0;
    b_rdata   = '0;

    unique case (owner_q)
      OWN_A: begin
        address   = a_addr;
        // A requester that withdraws on its grant cycle must not write.
        write     = a_write & a_req;
        to_memory = a_wdata;
        a_ack     = a_req;
        a_rdata   = from_memory;
      end
      OWN_B: begin
        address   = b_addr;
        write     = b_write & b_req;
        to_memory = b_wdata;
        b_ack     = b_req;
        b_rdata   = from_memory;
      end
      default: ;
    endcase
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (MAX_BURST=4). A small behavioural
// memory sits behind the arbiter; expected values are hand-computed. Inputs
// change 1 ns after the rising edge, outputs are sampled 2 ns after it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              a_req,  b_req;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_write, b_write;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              a_ack,  b_ack;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] to_memory;
  logic [DATA_W-1:0] from_memory;
  logic [1:0]        owner;

  int errors = 0;
  int checks = 0;

  // Behavioural memory; preload port used only while the DUT is in reset.
  logic [DATA_W-1:0] mem [256];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  assign from_memory = mem[address];

  always @(posedge clk) begin
    if (write)      mem[address] <= to_memory;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  mem_port_arbiter #(
    .MAX_BURST(4),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_write    (a_write),
    .a_wdata    (a_wdata),
    .a_rdata    (a_rdata),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_addr     (b_addr),
    .b_write    (b_write),
    .b_wdata    (b_wdata),
    .b_rdata    (b_rdata),
    .b_ack      (b_ack),
    .address    (address),
    .write      (write),
    .to_memory  (to_memory),
    .from_memory(from_memory),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drop both requests and let the arbiter return to NONE.
  task automatic go_idle();
    a_req   = 1'b0;
    b_req   = 1'b0;
    a_write = 1'b0;
    b_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    next_cycle();
    pl_en   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset   = 1'b0;
    a_req   = 1'b1;
    b_req   = 1'b1;
    a_write = 1'b1;
    a_addr  = 8'hF0;
    a_wdata = 8'hEE;
    b_write = 1'b0;
    b_addr  = 8'h00;
    b_wdata = 8'h00;
    preload(8'h3C, 8'hA5);
    preload(8'h10, 8'h00);
    preload(8'h20, 8'h11);
    preload(8'h30, 8'h00);
    #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b want 00", owner); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write); end
    checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got a=%b b=%b want 0 0", a_ack, b_ack); end
    checks++; if (address !== 8'h00 || to_memory !== 8'h00) begin errors++; $display("FAIL reset_bus: got addr=%h data=%h want 00 00", address, to_memory); end
    checks++; if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got a=%h b=%h want 00 00", a_rdata, b_rdata); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL reset_release_owner: got %b want 01", owner); end
    checks++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin errors++; $display("FAIL reset_release_ack: got a=%b b=%b want 1 0", a_ack, b_ack); end
    go_idle();
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b want 00", owner); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_idle_read();
    b_req   = 1'b1;
    b_addr  = 8'h3C;
    b_write = 1'b0;
    #1;
    checks++; if (owner !== 2'b00 || b_ack !== 1'b0) begin errors++; $display("FAIL idle_read_req_cycle: got owner=%b ack=%b want 00 0", owner, b_ack); end
    next_cycle(); #1;
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL idle_read_owner: got %b want 10", owner); end
    checks++; if (address !== 8'h3C) begin errors++; $display("FAIL idle_read_addr: got %h want 3c", address); end
    checks++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin errors++; $display("FAIL idle_read_ack: got b=%b a=%b want 1 0", b_ack, a_ack); end
    checks++; if (b_rdata !== 8'hA5) begin errors++; $display("FAIL idle_read_data: got %h want a5", b_rdata); end
    checks++; if (a_rdata !== 8'h00 || write !== 1'b0) begin errors++; $display("FAIL idle_read_other: got a_rdata=%h write=%b want 00 0", a_rdata, write); end
    next_cycle();
    b_req = 1'b0;
    #1;
    checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL idle_read_release: got ack=%b want 0", b_ack); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous_start();
    a_req  = 1'b1; a_addr = 8'h01; a_write = 1'b0;
    b_req  = 1'b1; b_addr = 8'h02; b_write = 1'b0;
    next_cycle(); #1;
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL simul_owner: got %b want 01", owner); end
    checks++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin errors++; $display("FAIL simul_ack: got a=%b b=%b want 1 0", a_ack, b_ack); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Both ports read continuously: A A A A B B B B A A A A B B B B.
  task automatic test_contention();
    logic [1:0] exp_owner;
    a_req  = 1'b1; a_addr = 8'h01; a_write = 1'b0;
    b_req  = 1'b1; b_addr = 8'h02; b_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_cycle(); #1;
      exp_owner = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      checks++; if (owner !== exp_owner) begin errors++; $display("FAIL contention_owner[%0d]: got %b want %b", i, owner, exp_owner); end
      checks++; if (a_ack !== (exp_owner == 2'b01) || b_ack !== (exp_owner == 2'b10)) begin errors++; $display("FAIL contention_ack[%0d]: got a=%b b=%b", i, a_ack, b_ack); end
      checks++; if (write !== 1'b0) begin errors++; $display("FAIL contention_write[%0d]: got %b want 0", i, write); end
    end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  // A's fourth access (the burst limit) writes 0x7E to 0x10 while B waits to
  // read 0x10; B is granted the very next cycle and sees the new data.
  task automatic test_write_handoff();
    a_req  = 1'b1; a_addr = 8'h01; a_write = 1'b0; a_wdata = 8'h00;
    b_req  = 1'b1; b_addr = 8'h10; b_write = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 4) begin
        a_write = 1'b1;
        a_addr  = 8'h10;
        a_wdata = 8'h7E;
      end
      #1;
      checks++; if (owner !== 2'b01 || a_ack !== 1'b1) begin errors++; $display("FAIL handoff_a[%0d]: got owner=%b ack=%b want 01 1", k, owner, a_ack); end
    end
    checks++; if (write !== 1'b1 || address !== 8'h10 || to_memory !== 8'h7E) begin errors++; $display("FAIL handoff_write: got w=%b addr=%h data=%h want 1 10 7e", write, address, to_memory); end
    next_cycle();
    a_req   = 1'b0;
    a_write = 1'b0;
    #1;
    checks++; if (owner !== 2'b10 || b_ack !== 1'b1 || a_ack !== 1'b0) begin errors++; $display("FAIL handoff_b_ack: got owner=%b b=%b a=%b want 10 1 0", owner, b_ack, a_ack); end
    checks++; if (b_rdata !== 8'h7E) begin errors++; $display("FAIL handoff_b_data: got %h want 7e", b_rdata); end
    next_cycle();
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  // A runs alone long enough for burst_cnt to saturate at 15; a later B
  // request must then win at the very next edge.
  task automatic test_burst_saturation();
    a_req = 1'b1; a_addr = 8'h02; a_write = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      next_cycle();
      if (k == 17) begin
        b_req  = 1'b1;
        b_addr = 8'h03;
      end
    end
    #1;
    checks++; if (owner !== 2'b01 || a_ack !== 1'b1) begin errors++; $display("FAIL sat_a_owner: got owner=%b ack=%b want 01 1", owner, a_ack); end
    next_cycle(); #1;
    checks++; if (owner !== 2'b10 || b_ack !== 1'b1) begin errors++; $display("FAIL sat_switch: got owner=%b b_ack=%b want 10 1", owner, b_ack); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  // A write request withdrawn in its grant cycle performs no access.
  task automatic test_drop_request();
    a_req = 1'b1; a_addr = 8'h30; a_write = 1'b1; a_wdata = 8'h99;
    next_cycle();
    a_req = 1'b0;
    #1;
    checks++; if (owner !== 2'b01 || a_ack !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL drop_req: got owner=%b ack=%b write=%b want 01 0 0", owner, a_ack, write); end
    go_idle();
    checks++; if (mem[8'h30] !== 8'h00) begin errors++; $display("FAIL drop_req_mem: got %h want 00", mem[8'h30]); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_abort();
    b_req = 1'b1; b_addr = 8'h20; b_write = 1'b1; b_wdata = 8'h55;
    next_cycle(); #1;
    checks++; if (owner !== 2'b10 || write !== 1'b1 || b_ack !== 1'b1) begin errors++; $display("FAIL abort_pre: got owner=%b write=%b ack=%b want 10 1 1", owner, write, b_ack); end
    reset = 1'b0;
    #1;
    checks++; if (write !== 1'b0 || b_ack !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL abort_async: got write=%b ack=%b owner=%b want 0 0 00", write, b_ack, owner); end
    b_req   = 1'b0;
    b_write = 1'b0;
    next_cycle();
    checks++; if (mem[8'h20] !== 8'h11) begin errors++; $display("FAIL abort_mem: got %h want 11", mem[8'h20]); end
    @(negedge clk);
    reset = 1'b1;
    next_cycle(); #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL abort_after: got %b want 00", owner); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset   = 1'b0;
    a_req   = 1'b0; a_addr = '0; a_write = 1'b0; a_wdata = '0;
    b_req   = 1'b0; b_addr = '0; b_write = 1'b0; b_wdata = '0;
    pl_en   = 1'b0; pl_addr = '0; pl_data = '0;

    test_reset();
    test_idle_read();
    test_simultaneous_start();
    test_contention();
    test_write_handoff();
    test_burst_saturation();
    test_drop_request();
    test_async_abort();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single 8-bit memory port between two requesters: the CPU core (port A) and a DMA/program-loader engine (port B).
- Sits between the CPU's memory interface and the memory block. It drives the memory's address, write and write-data lines from the granted requester and returns read data and per-port acknowledges.
- Uses fixed CPU priority from idle, bounded bursts for fairness, and one access per granted cycle.

Parameters:
- MAX_BURST, 4: maximum consecutive granted cycles for one owner while the other port is requesting; range 1..15.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- a_req  in  1  CPU access request; held until a_ack is sampled high.
- a_addr  in  ADDR_W  CPU address.
- a_write  in  1  CPU write (1) or read (0).
- a_wdata  in  DATA_W  CPU write data.
- a_rdata  out  DATA_W  read data to CPU; valid while a_ack=1 and a_write=0.
- a_ack  out  1  CPU access performed this cycle.
- b_req, b_addr, b_write, b_wdata, b_rdata, b_ack: same as the port A signals, for the DMA/loader.
- address  out  ADDR_W  memory address.
- write  out  1  memory write enable; memory commits on the clk edge ending the cycle.
- to_memory  out  DATA_W  memory write data.
- from_memory  in  DATA_W  memory read data; combinational from address.
- owner  out  2  current owner: 00 = NONE, 01 = A, 10 = B; 11 is never driven.

Behaviour:
- State: owner register (NONE/A/B) and burst counter burst_cnt (4 bits).
- Reset (reset=0, asynchronous):
  - owner=NONE, burst_cnt=0.
  - a_ack=b_ack=0, write=0, address=0, to_memory=0, a_rdata=b_rdata=0.
  - Assertion mid-access forces write low immediately; the in-flight access is not acknowledged and its requester must re-request.
- Output decode (combinational from owner):
  - owner=A: address/write/to_memory follow a_addr/(a_write&a_req)/a_wdata; a_ack=a_req; a_rdata=from_memory.
  - owner=B: the same, using the port B signals.
  - owner=NONE: write=0, address=0, to_memory=0, both acks 0.
  - The non-owner's ack is 0 and its rdata is 0.
- Next owner at each rising edge. Let cur = owner, oth = the other port.
  - NONE: if a_req, go to A; else if b_req, go to B; else stay NONE. Both requesting: A wins.
  - Owner X, X requesting, oth not requesting: stay X.
  - Owner X, X requesting, oth requesting, burst_cnt+1 < MAX_BURST: stay X.
  - Owner X, X requesting, oth requesting, burst_cnt+1 >= MAX_BURST: switch to oth.
  - Owner X, X not requesting: go to oth if it is requesting, else NONE.
- burst_cnt:
  - Cleared on any owner change.
  - Incremented when owner stays the same with its req high, saturating at 15.
  - Compared only while the other port is requesting.
- Latency:
  - From idle, a request rising in cycle N gets its ack in cycle N+1.
  - A waiting requester is granted within MAX_BURST+1 cycles.
- Handshake:
  - A requester holds req/addr/write/wdata stable until the clock edge at which it samples ack=1.
  - It may then deassert req or present the next access in the following cycle, giving back-to-back accesses at 1 per cycle.
  - Read data is captured by the requester on the edge where ack=1.
- Owner switch never produces a bubble when the other port is waiting: the last ack of X is in cycle N and the first ack of oth is in cycle N+1.
- A requester that drops req in the same cycle its ack would occur gets no access; no write is issued because write is gated by req.
- MAX_BURST=1 gives strict alternation while both ports request.

Test Plan:
- Reset: hold reset=0 with a_req=b_req=1 and a_write=1 → owner=00, write=0, a_ack=b_ack=0. Release reset → owner=01 at the next edge; a_ack=1 in that cycle.
- Idle read: b_req=1, b_addr=0x3C, b_write=0 with memory[0x3C]=0xA5 → next cycle owner=10, address=0x3C, b_ack=1, b_rdata=0xA5.
- Simultaneous start: a_req and b_req both rise in the same cycle → A granted first.
- Contention with MAX_BURST=4: a_req and b_req held high continuously → a_ack high 4 cycles, b_ack high 4 cycles, alternating; write never asserted while owner=00.
- Write handoff: A writes 0x7E to 0x10, then drops a_req while b_req is held reading 0x10 → b_ack the cycle after a's last ack, b_rdata=0x7E, no idle cycle between.
- Async abort: assert reset mid-way through a B write to 0x20 (data 0x55) → write drops the same cycle without a clock edge, memory[0x20] unchanged, b_ack=0.
